sipo_dff: RTL and testbench

- 4-stage serial-in, parallel-out shift register built from four D flip-flops in a chain.
- Each rising clock edge captures one serial bit on Din into stage Q1 and shifts every stage one position toward Q4.
- After four edges the last four serial bits are available in parallel on Q1..Q4; Q4 holds the oldest bit.
- Used as a small serial-to-parallel converter at the edge of a datapath.

---
 rtl/sipo_dff_cell.sv | 28 ++
 rtl/sipo_dff.sv | 47 ++++
 tb/tb_sipo_dff.sv | 113 +++++++++++
 3 files changed

// File: rtl/sipo_dff_cell.sv
// dff_cell: one stage of the serial-in, parallel-out chain.
// A 1-bit D flip-flop that clears to 0 as soon as Rst_n goes low.
//   Clk   : rising-edge clock
//   Rst_n : asynchronous reset, active low, clears Q to 0
//   D     : data in, sampled on the rising edge of Clk
//   Q     : registered data out
module dff_cell (
   input  logic Clk,
   input  logic Rst_n,
   input  logic D,
   output logic Q
);

   logic q_d;
   logic q_q;

   always_comb begin
      q_d = D;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) q_q <= 1'b0;
      else        q_q <= q_d;
   end

   assign Q = q_q;

endmodule

// File: rtl/sipo_dff.sv
// sipo_dff: 4-stage serial-in, parallel-out shift register.
// Each rising edge of Clk captures Din into stage 1 and moves every stage
// one place toward stage 4. A word sent LSB first reads back as
// {Q1,Q2,Q3,Q4} after four edges.
//   Clk   : rising-edge clock
//   Rst_n : asynchronous reset, active low, clears every stage
//   Din   : serial data in
//   Q1    : newest bit (Din from the last edge)
//   Q2    : Din from 2 edges ago
//   Q3    : Din from 3 edges ago
//   Q4    : oldest bit (Din from 4 edges ago)
module sipo_dff (
   input  logic Clk,
   input  logic Rst_n,
   input  logic Din,
   output logic Q1,
   output logic Q2,
   output logic Q3,
   output logic Q4
);

   localparam int STAGES = 4;

   // stage_q[i] is the output of stage i+1; stage_d[i] feeds it.
   logic [STAGES-1:0] stage_q;
   logic [STAGES-1:0] stage_d;

   // Stage 1 takes the serial input; every later stage takes its neighbour.
   always_comb begin
      stage_d = {stage_q[STAGES-2:0], Din};
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      dff_cell u_cell (
         .Clk   (Clk),
         .Rst_n (Rst_n),
         .D     (stage_d[i]),
         .Q     (stage_q[i])
      );
   end

   assign Q1 = stage_q[0];
   assign Q2 = stage_q[1];
   assign Q3 = stage_q[2];
   assign Q4 = stage_q[3];

endmodule

// File: tb/tb_sipo_dff.sv
// Directed bench for sipo_dff. Expected words are written as {Q1,Q2,Q3,Q4}.
module tb_sipo_dff;

   logic Clk;
   logic Rst_n;
   logic Din;
   logic Q1, Q2, Q3, Q4;
   logic [3:0] qv;
   logic [3:0] held;
   logic       mq[$];
   int checks;
   int errors;

   assign qv = {Q1, Q2, Q3, Q4};

   sipo_dff dut (
      .Clk   (Clk),
      .Rst_n (Rst_n),
      .Din   (Din),
      .Q1    (Q1),
      .Q2    (Q2),
      .Q3    (Q3),
      .Q4    (Q4)
   );

   // Period 20, rising edges at 10, 30, 50, ...
   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %b want %b", tag, obs, exp);
      end
   endtask

   // Wait for the next edge, change Din 2 units later, check 3 units after that.
   task automatic step(input logic nxt, input string tag, input logic [3:0] exp);
      @(posedge Clk);
      #2 Din = nxt;
      #3 chk(tag, qv, exp);
   endtask

   function automatic logic [3:0] model_word();
      return {mq[0], mq[1], mq[2], mq[3]};
   endfunction

   initial begin
      checks = 0;
      errors = 0;
      Rst_n  = 1'b0;
      Din    = 1'b1;

      // Reset held low with Din=1 and the clock running.
      #1 chk("reset_t1", qv, 4'b0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge Clk);
         #5 chk("reset_hold", qv, 4'b0000);
      end

      // Release between edges, then load 1011 LSB first.
      Rst_n = 1'b1;
      Din   = 1'b0;
      step(1'b1, "load_e1", 4'b0000);
      step(1'b1, "load_e2", 4'b1000);
      step(1'b0, "load_e3", 4'b1100);
      step(1'b1, "load_e4", 4'b0110);
      step(1'b1, "load_e5", 4'b1011);
      // One more 1: oldest bit falls off the end.
      step(1'b1, "cont_shift", 4'b1101);

      // Fill with ones, then reset between edges.
      step(1'b1, "fill_a", 4'b1110);
      step(1'b1, "fill_b", 4'b1111);
      Rst_n = 1'b0;
      #1 chk("midreset_async", qv, 4'b0000);
      @(posedge Clk);
      #5 chk("midreset_edge", qv, 4'b0000);

      // Walking one from a cleared register.
      Rst_n = 1'b1;
      Din   = 1'b1;
      step(1'b0, "walk_1", 4'b1000);
      chk("walk_onehot1", 4'($countones(qv)), 4'd1);
      step(1'b0, "walk_2", 4'b0100);
      step(1'b0, "walk_3", 4'b0010);
      step(1'b0, "walk_4", 4'b0001);
      chk("walk_onehot4", 4'($countones(qv)), 4'd1);
      step(1'b0, "walk_5", 4'b0000);

      // Random Din against a 4-deep queue model, with Din glitched between edges.
      mq = {1'b0, 1'b0, 1'b0, 1'b0};
      Din = 1'($urandom_range(0, 1));
      for (int c = 0; c < 100; c++) begin
         @(posedge Clk);
         mq.push_front(Din);
         void'(mq.pop_back());
         #3 chk("rand_shift", qv, model_word());
         held = qv;
         #2 Din = ~Din;
         #1 Din = ~Din;
         #1 Din = ~Din;
         chk("rand_glitch", qv, model_word());
         #2 Din = 1'($urandom_range(0, 1));
      end
      held = qv;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
